// File: rtl/instruction_fetch_unit_pkg.sv
// Shared instruction-set definitions for the fetch path: opcodes, register codes
// and the bit layout of the 28-bit instruction word.
package instruction_fetch_unit_pkg;

    localparam int INSTR_W = 28;
    localparam int ADDR_W  = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_LED = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;

    localparam logic [7:0] R0 = 8'd0;
    localparam logic [7:0] R1 = 8'd1;
    localparam logic [7:0] R2 = 8'd2;
    localparam logic [7:0] R3 = 8'd3;

    localparam int OPC_HI  = 27;
    localparam int OPC_LO  = 24;
    localparam int DEST_HI = 23;
    localparam int DEST_LO = 16;
    localparam int SRC1_HI = 15;
    localparam int SRC1_LO = 8;
    localparam int SRC0_HI = 7;
    localparam int SRC0_LO = 0;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational ROM and hands a registered,
// field-split instruction to execute. Resolves JMP locally and halts on a self-jump.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_ADDR        = 16'd0,
    parameter bit          HALT_ON_SELF_JUMP = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    output logic        oValid,
    output logic [27:0] oInstruction,
    output logic [15:0] oPC,
    output logic [3:0]  oOpcode,
    output logic [7:0]  oDest,
    output logic [7:0]  oSrc1,
    output logic [7:0]  oSrc0,
    output logic [15:0] oImm,
    output logic        oHalted
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic [27:0] r_instr, w_instr_nxt;
    logic [15:0] r_opc, w_opc_nxt;

    logic        w_is_jmp;
    logic [15:0] w_jmp_target;

    assign w_is_jmp     = (opcode_of(iInstruction) == OP_JMP);
    assign w_jmp_target = iInstruction[IMM_HI:IMM_LO];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_START;
            r_pc    <= RESET_ADDR;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_opc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
            r_opc   <= w_opc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_opc_nxt   = r_opc;
        case (r_state)
            ST_START: begin
                w_state_nxt = ST_RUN;
                w_valid_nxt = 1'b0;
            end
            ST_RUN: begin
                // A redirect squashes the word on the bus and wins even over a stall.
                if (iBranchTaken) begin
                    w_pc_nxt    = iBranchTarget;
                    w_valid_nxt = 1'b0;
                end else if (!iStall) begin
                    w_instr_nxt = iInstruction;
                    w_opc_nxt   = r_pc;
                    w_valid_nxt = 1'b1;
                    if (w_is_jmp) begin
                        w_pc_nxt = w_jmp_target;
                        if (HALT_ON_SELF_JUMP && (w_jmp_target == r_pc)) begin
                            w_state_nxt = ST_HALT;
                            w_valid_nxt = 1'b0;
                        end
                    end else begin
                        w_pc_nxt = r_pc + 16'd1;
                    end
                end
            end
            ST_HALT: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_START;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign oAddress     = r_pc;
    assign oValid       = r_valid;
    assign oInstruction = r_instr;
    assign oPC          = r_opc;
    assign oHalted      = (r_state == ST_HALT);

    assign oOpcode = r_instr[OPC_HI:OPC_LO];
    assign oDest   = r_instr[DEST_HI:DEST_LO];
    assign oSrc1   = r_instr[SRC1_HI:SRC1_LO];
    assign oSrc0   = r_instr[SRC0_HI:SRC0_LO];
    assign oImm    = r_instr[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: combinational ROM model plus a queue of
// expected (pc, word) pairs drained whenever execute accepts a valid word.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    typedef struct {
        logic [15:0] pc;
        logic [27:0] word;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        iStall = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [15:0] iBranchTarget = 16'h0;
    logic        oValid;
    logic [27:0] oInstruction;
    logic [15:0] oPC;
    logic [3:0]  oOpcode;
    logic [7:0]  oDest;
    logic [7:0]  oSrc1;
    logic [7:0]  oSrc0;
    logic [15:0] oImm;
    logic        oHalted;

    logic [27:0] rom [0:65535];
    exp_t        exp_q[$];
    logic        sb_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    instruction_fetch_unit #(
        .RESET_ADDR(16'd0),
        .HALT_ON_SELF_JUMP(1'b1)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .oAddress(oAddress),
        .iInstruction(iInstruction),
        .iStall(iStall),
        .iBranchTaken(iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .oValid(oValid),
        .oInstruction(oInstruction),
        .oPC(oPC),
        .oOpcode(oOpcode),
        .oDest(oDest),
        .oSrc1(oSrc1),
        .oSrc0(oSrc0),
        .oImm(oImm),
        .oHalted(oHalted)
    );

    always #5 Clock = ~Clock;

    assign iInstruction = rom[oAddress];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    // Default fill never uses the JMP opcode; some words carry an undefined opcode.
    function automatic logic [27:0] def_word(input int a);
        logic [15:0] adr;
        logic [3:0]  op;
        adr = a[15:0];
        op  = (adr[2:0] == 3'd6) ? 4'hF : {2'b00, adr[1:0]};
        return {op, adr[7:0] ^ 8'hA5, adr};
    endfunction

    task automatic rom_fill();
        for (int a = 0; a < 65536; a++) rom[a] = def_word(a);
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = rom[pc];
        exp_q.push_back(e);
    endtask

    // Advance one cycle; mid-cycle, a valid unstalled word is taken by execute.
    task automatic tick();
        exp_t e;
        @(negedge Clock);
        if (sb_en && oValid && !iStall) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: got pc=%h word=%h, required no valid word", oPC, oInstruction);
            end else begin
                e = exp_q.pop_front();
                if (oPC !== e.pc || oInstruction !== e.word || oOpcode !== e.word[27:24] ||
                    oDest !== e.word[23:16] || oSrc1 !== e.word[15:8] ||
                    oSrc0 !== e.word[7:0] || oImm !== e.word[15:0]) begin
                    n_errors++;
                    $display("FAIL sb_word: got pc=%h word=%h op=%h dst=%h s1=%h s0=%h imm=%h, required pc=%h word=%h",
                             oPC, oInstruction, oOpcode, oDest, oSrc1, oSrc0, oImm, e.pc, e.word);
                end
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        exp_q.delete();
        Reset = 1'b1;
        iStall = 1'b0;
        iBranchTaken = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        rom_fill();
        do_reset();
        n_checks++;
        if (oValid !== 1'b0 || oInstruction !== 28'h0 || oPC !== 16'h0 || oHalted !== 1'b0 ||
            oOpcode !== 4'h0 || oDest !== 8'h0 || oSrc1 !== 8'h0 || oSrc0 !== 8'h0 || oImm !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b ins=%h pc=%h h=%b, required all zero",
                     oValid, oInstruction, oPC, oHalted);
        end
        n_checks++;
        if (oAddress !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_addr: got %h, required 0000", oAddress);
        end
    endtask

    task automatic test_sequential();
        rom_fill();
        do_reset();
        for (int i = 0; i < 8; i++) push_exp(i[15:0]);
        sb_en = 1'b1;
        n_checks++;
        if (oAddress !== 16'd0 || oValid !== 1'b0) begin
            n_errors++;
            $display("FAIL seq_start: got addr=%h v=%b, required addr=0000 v=0", oAddress, oValid);
        end
        tick();
        n_checks++;
        if (oAddress !== 16'd0 || oValid !== 1'b0) begin
            n_errors++;
            $display("FAIL seq_first_fetch: got addr=%h v=%b, required addr=0000 v=0", oAddress, oValid);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (oAddress !== k[15:0] || oValid !== 1'b1) begin
                n_errors++;
                $display("FAIL seq_addr: got addr=%h v=%b, required addr=%h v=1", oAddress, oValid, k[15:0]);
            end
        end
        tick();
        sb_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL seq_drain: got %0d words left, required 0", exp_q.size());
        end
    endtask

    task automatic test_jmp();
        int addrs[$] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 2, 3, 4, 5};
        int pcs[$]   = '{0, 1, 2, 3, 4, 5, 6, 7, 2, 3, 4};
        rom_fill();
        rom[7] = {OP_JMP, 8'd0, 16'd2};
        do_reset();
        foreach (pcs[i]) push_exp(pcs[i][15:0]);
        sb_en = 1'b1;
        foreach (addrs[i]) begin
            if (i > 0) tick();
            n_checks++;
            if (oAddress !== addrs[i][15:0]) begin
                n_errors++;
                $display("FAIL jmp_addr[%0d]: got %h, required %h", i, oAddress, addrs[i][15:0]);
            end
        end
        tick();
        sb_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL jmp_drain: got %0d words left, required 0", exp_q.size());
        end
    endtask

    task automatic test_self_jump_halt();
        rom_fill();
        rom[3] = {OP_JMP, 8'd0, 16'd3};
        do_reset();
        for (int i = 0; i < 3; i++) push_exp(i[15:0]);
        sb_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        for (int c = 0; c < 12; c++) begin
            if (c == 3) begin
                iBranchTaken  = 1'b1;
                iBranchTarget = 16'h0020;
            end else begin
                iBranchTaken = 1'b0;
            end
            n_checks++;
            if (oAddress !== 16'd3 || oHalted !== 1'b1 || oValid !== 1'b0) begin
                n_errors++;
                $display("FAIL halt_hold[%0d]: got addr=%h h=%b v=%b, required addr=0003 h=1 v=0",
                         c, oAddress, oHalted, oValid);
            end
            tick();
        end
        iBranchTaken = 1'b0;
        sb_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL halt_drain: got %0d words left, required 0", exp_q.size());
        end
        do_reset();
        n_checks++;
        if (oHalted !== 1'b0 || oAddress !== 16'd0 || oValid !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_reset: got h=%b addr=%h v=%b, required h=0 addr=0000 v=0", oHalted, oAddress, oValid);
        end
        tick();
        tick();
        n_checks++;
        if (oAddress !== 16'd1 || oValid !== 1'b1 || oPC !== 16'd0) begin
            n_errors++;
            $display("FAIL halt_restart: got addr=%h v=%b pc=%h, required addr=0001 v=1 pc=0000", oAddress, oValid, oPC);
        end
    endtask

    task automatic test_stall();
        rom_fill();
        do_reset();
        for (int i = 0; i < 6; i++) push_exp(i[15:0]);
        sb_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        iStall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) iStall = 1'b0;
            n_checks++;
            if (oPC !== 16'd4 || oAddress !== 16'd5 || oInstruction !== rom[4] || oValid !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got pc=%h addr=%h ins=%h v=%b, required pc=0004 addr=0005 ins=%h v=1",
                         c, oPC, oAddress, oInstruction, oValid, rom[4]);
            end
            tick();
        end
        n_checks++;
        if (oPC !== 16'd5 || oAddress !== 16'd6) begin
            n_errors++;
            $display("FAIL stall_resume: got pc=%h addr=%h, required pc=0005 addr=0006", oPC, oAddress);
        end
        tick();
        sb_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL stall_drain: got %0d words left, required 0", exp_q.size());
        end
    endtask

    task automatic test_branch_stall();
        rom_fill();
        do_reset();
        push_exp(16'd0);
        push_exp(16'd1);
        push_exp(16'h0010);
        push_exp(16'h0011);
        sb_en = 1'b1;
        iBranchTaken  = 1'b1;
        iBranchTarget = 16'h0040;
        tick();
        iBranchTaken = 1'b0;
        n_checks++;
        if (oAddress !== 16'd0) begin
            n_errors++;
            $display("FAIL branch_in_start: got addr=%h, required 0000", oAddress);
        end
        for (int i = 0; i < 3; i++) tick();
        iBranchTaken  = 1'b1;
        iBranchTarget = 16'h0010;
        iStall        = 1'b1;
        tick();
        iBranchTaken = 1'b0;
        iStall       = 1'b0;
        n_checks++;
        if (oValid !== 1'b0 || oAddress !== 16'h0010) begin
            n_errors++;
            $display("FAIL branch_squash: got v=%b addr=%h, required v=0 addr=0010", oValid, oAddress);
        end
        tick();
        n_checks++;
        if (oValid !== 1'b1 || oPC !== 16'h0010 || oAddress !== 16'h0011) begin
            n_errors++;
            $display("FAIL branch_target: got v=%b pc=%h addr=%h, required v=1 pc=0010 addr=0011", oValid, oPC, oAddress);
        end
        tick();
        tick();
        sb_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL branch_drain: got %0d words left, required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap_and_reset();
        rom_fill();
        do_reset();
        push_exp(16'd0);
        push_exp(16'hFFFF);
        push_exp(16'd0);
        sb_en = 1'b1;
        tick();
        tick();
        iBranchTaken  = 1'b1;
        iBranchTarget = 16'hFFFF;
        tick();
        iBranchTaken = 1'b0;
        n_checks++;
        if (oValid !== 1'b0 || oAddress !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL wrap_redirect: got v=%b addr=%h, required v=0 addr=ffff", oValid, oAddress);
        end
        tick();
        n_checks++;
        if (oPC !== 16'hFFFF || oAddress !== 16'h0000 || oValid !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_addr: got pc=%h addr=%h v=%b, required pc=ffff addr=0000 v=1", oPC, oAddress, oValid);
        end
        tick();
        Reset = 1'b1;
        tick();
        sb_en = 1'b0;
        n_checks++;
        if (oValid !== 1'b0 || oInstruction !== 28'h0 || oPC !== 16'h0 || oHalted !== 1'b0 ||
            oAddress !== 16'h0 || oImm !== 16'h0 || oOpcode !== 4'h0) begin
            n_errors++;
            $display("FAIL midrun_reset: got v=%b ins=%h pc=%h h=%b addr=%h, required zeros and addr=0000",
                     oValid, oInstruction, oPC, oHalted, oAddress);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL wrap_drain: got %0d words left, required 0", exp_q.size());
        end
        Reset = 1'b0;
        tick();
        n_checks++;
        if (oAddress !== 16'h0 || oValid !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_start: got addr=%h v=%b, required addr=0000 v=0", oAddress, oValid);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jmp();
        test_self_jump_halt();
        test_stall();
        test_branch_stall();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Reader side of the instruction ROM interface.
- Owns the program counter and drives the 16-bit ROM address.
- Captures the 28-bit instruction the ROM returns combinationally and presents it, pre-split into fields, to the execute stage through a registered valid/stall stage.
- Resolves unconditional JMP locally, accepts branch redirects from execute, and halts on a self-jump.

Parameters:
RESET_ADDR, 16'd0, PC value loaded on Reset and first address fetched.
HALT_ON_SELF_JUMP, 1, when 1 a JMP whose target equals its own PC enters HALT.

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
oAddress  output  16  ROM address, equals PC register
iInstruction  input  28  ROM data for oAddress, same cycle (combinational ROM)
iStall  input  1  execute not ready; hold the output stage and PC
iBranchTaken  input  1  execute redirect request, single-cycle pulse
iBranchTarget  input  16  redirect address, valid with iBranchTaken
oValid  output  1  output stage holds a live instruction
oInstruction  output  28  registered instruction word
oPC  output  16  address oInstruction was fetched from
oOpcode  output  4  oInstruction[27:24]
oDest  output  8  oInstruction[23:16]
oSrc1  output  8  oInstruction[15:8]
oSrc0  output  8  oInstruction[7:0]
oImm  output  16  oInstruction[15:0]
oHalted  output  1  high while in HALT

Behaviour:
- Reset, synchronous and dominant over everything else:
  - state=START, PC=RESET_ADDR.
  - oValid=0, oInstruction=0, oPC=0, oHalted=0.
  - Field outputs follow oInstruction, so they are also 0.
- FSM states:
  - START: one bubble cycle. oValid=0, PC held. Next state RUN.
  - RUN: normal fetch.
  - HALT: PC frozen, oValid=0, oHalted=1. Leaves only on Reset.
- RUN, priority highest first:
  1. iBranchTaken=1:
     - PC<=iBranchTarget.
     - oValid<=0, squashing the word fetched this cycle.
     - Overrides iStall.
  2. iStall=1:
     - PC, oValid, oInstruction and oPC all hold.
     - ROM output is ignored.
  3. Otherwise:
     - oInstruction<=iInstruction, oPC<=PC, oValid<=1.
     - Opcode = iInstruction[27:24] (fetch-time opcode).
     - If opcode == `JMP: PC<=iInstruction[15:0].
       - If HALT_ON_SELF_JUMP=1 and iInstruction[15:0]==PC: state<=HALT and oValid<=0 instead.
     - Any other opcode: PC<=PC+1, mod 2^16, so 16'hFFFF wraps to 16'h0000.
- JMP:
  - Zero-bubble redirect.
  - The JMP word itself is forwarded (oValid=1); execute treats it as a no-op.
- Latency:
  - Address presented in cycle n appears on oInstruction with oValid=1 after the edge ending cycle n.
  - Throughput is 1 instruction per cycle absent stalls and branches.
- iBranchTaken in START or HALT is ignored.
- iBranchTarget is only sampled when iBranchTaken=1.
- Field outputs are pure slices of oInstruction and carry no extra latency.
- Undefined opcodes are forwarded unchanged. The default ROM fill word is forwarded like any other.

Decomposition:
- Opcode constants (`NOP, `STO, `MUL, `LED, `JMP, ...) and register codes (`R0.. ) live in the shared definitions include. This block only compares against `JMP.
- Field bit positions (opcode [27:24], dest [23:16], src1 [15:8], src0 [7:0], imm [15:0]) are added to the same include as shared constants.
- FSM state encodings are local localparams.
- No sub-module. PC logic, FSM and output register stay in one module.

Test Plan:
- Sequential fetch:
  - Stimulus: Reset for 2 cycles, ROM words 0..7 non-JMP.
  - Response: oAddress 0,0(START),1,2,...; oValid rises the cycle after START; oPC 0,1,2...; oInstruction matches ROM word at oPC.
- JMP:
  - Stimulus: word 7 = {`JMP,8'd0,16'd2}.
  - Response: after fetching 7, oAddress=2 next cycle; JMP forwarded with oValid=1 and oPC=7; no bubble.
- Self-jump halt:
  - Stimulus: word 3 = {`JMP,8'd0,16'd3}.
  - Response: oHalted=1 and oValid=0 from the next cycle; oAddress stays 3 for 10+ cycles; Reset returns to address 0.
- Stall:
  - Stimulus: iStall high 3 cycles while oPC=4.
  - Response: oPC, oInstruction and oAddress (5) frozen; resume with oPC=5 the cycle after iStall falls.
- Branch with stall:
  - Stimulus: iBranchTaken=1, iBranchTarget=16'h0010 with iStall=1.
  - Response: next cycle oValid=0 and oAddress=16'h0010; the following cycle oPC=16'h0010.
- Wrap and mid-run reset:
  - Stimulus (wrap): iBranchTarget=16'hFFFF, non-JMP word there.
  - Response: next address 16'h0000.
  - Stimulus (reset): Reset asserted mid-run.
  - Response: outputs zero, oAddress=RESET_ADDR on the following cycle.
